// File: rtl/sdram_axi_burst_bridge.sv
// AXI4 slave front-end that splits FIXED/INCR/WRAP bursts into single-word SDRAM requests.
// Reads are credit-limited into a small response FIFO; writes collect acks into one B response.
module sdram_axi_burst_bridge #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int RESP_DEPTH = 4,
  localparam int STRB_W    = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  // AXI write address
  input  logic              in_awvalid,
  output logic              in_awready,
  input  logic [ADDR_W-1:0] in_awaddr,
  input  logic [ID_W-1:0]   in_awid,
  input  logic [7:0]        in_awlen,
  input  logic [2:0]        in_awsize,
  input  logic [1:0]        in_awburst,
  // AXI write data
  input  logic              in_wvalid,
  output logic              in_wready,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [STRB_W-1:0] in_wstrb,
  input  logic              in_wlast,
  // AXI write response
  output logic              in_bvalid,
  input  logic              in_bready,
  output logic [1:0]        in_bresp,
  output logic [ID_W-1:0]   in_bid,
  // AXI read address
  input  logic              in_arvalid,
  output logic              in_arready,
  input  logic [ADDR_W-1:0] in_araddr,
  input  logic [ID_W-1:0]   in_arid,
  input  logic [7:0]        in_arlen,
  input  logic [2:0]        in_arsize,
  input  logic [1:0]        in_arburst,
  // AXI read data
  output logic              in_rvalid,
  input  logic              in_rready,
  output logic [DATA_W-1:0] in_rdata,
  output logic [1:0]        in_rresp,
  output logic              in_rlast,
  output logic [ID_W-1:0]   in_rid,
  // word-level memory port
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [STRB_W-1:0] mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  input  logic              mem_resp_err,
  output logic [1:0]        dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a valid, once raised, is held with stable payload until that edge.

  localparam int OFS   = $clog2(STRB_W);
  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, WR_RESP = 2'd3} state_t;

  state_t            state, state_nxt;
  logic              prio;  // 0: read wins a tie, 1: write wins
  logic [ADDR_W-1:0] cur_addr, addr_nxt;
  logic [ID_W-1:0]   cur_id;
  logic [7:0]        cur_len;
  logic [2:0]        cur_size;
  logic [1:0]        cur_burst;
  logic [8:0]        issued, acks, len_p1;
  logic [7:0]        popped;
  logic              wr_err;
  logic [CNT_W-1:0]  outstanding, fifo_count;
  logic [PTR_W-1:0]  wptr, rptr;
  logic [DATA_W:0]   fifo_mem [RESP_DEPTH];
  logic [DATA_W:0]   head;

  logic grant_rd, grant_wr, ar_fire, aw_fire;
  logic beats_left, credit_ok, rd_issue, wr_issue, req_fire, rd_fire;
  logic push, pop;
  logic [ADDR_W-1:0] incr, aligned, wrap_mask;
  logic wlast_unused;

  // Burst length always comes from the address phase; wlast carries no extra information.
  assign wlast_unused = in_wlast;

  assign grant_rd   = in_arvalid && (!in_awvalid || !prio);
  assign grant_wr   = in_awvalid && (!in_arvalid || prio);
  assign in_arready = (state == IDLE) && !reset && grant_rd;
  assign in_awready = (state == IDLE) && !reset && grant_wr;
  assign ar_fire    = in_arvalid && in_arready;
  assign aw_fire    = in_awvalid && in_awready;

  assign len_p1     = {1'b0, cur_len} + 9'd1;
  assign beats_left = issued <= {1'b0, cur_len};
  assign credit_ok  = ({1'b0, outstanding} + {1'b0, fifo_count}) < (CNT_W + 1)'(RESP_DEPTH);
  assign rd_issue   = (state == RD) && beats_left && credit_ok;
  assign wr_issue   = (state == WR) && beats_left && in_wvalid;
  assign req_fire   = mem_req_valid && mem_req_ready;
  assign rd_fire    = rd_issue && mem_req_ready;

  assign mem_req_valid = rd_issue || wr_issue;
  assign in_wready     = wr_issue && mem_req_ready;
  assign mem_req_we    = (state == WR);
  assign mem_req_addr  = {cur_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
  assign mem_req_wdata = (state == WR) ? in_wdata : '0;
  assign mem_req_wstrb = (state == WR) ? in_wstrb : '0;

  // Narrow INCR beats after an unaligned start snap to the next size-aligned address.
  assign incr      = ADDR_W'(1) << cur_size;
  assign aligned   = cur_addr & ~(incr - ADDR_W'(1));
  assign wrap_mask = ((ADDR_W'(cur_len) + ADDR_W'(1)) << cur_size) - ADDR_W'(1);

  always_comb begin
    addr_nxt = aligned + incr;
    case (cur_burst)
      2'b00:   addr_nxt = cur_addr;
      2'b10:   addr_nxt = (cur_addr & ~wrap_mask) | ((cur_addr + incr) & wrap_mask);
      default: ;
    endcase
  end

  assign push      = (state == RD) && mem_resp_valid;
  assign pop       = in_rvalid && in_rready;
  assign head      = fifo_mem[rptr];
  assign in_rvalid = (fifo_count != '0);
  assign in_rdata  = in_rvalid ? head[DATA_W-1:0] : '0;
  assign in_rresp  = (in_rvalid && head[DATA_W]) ? 2'b10 : 2'b00;
  assign in_rlast  = in_rvalid && (popped == cur_len);
  assign in_rid    = cur_id;
  assign in_bvalid = (state == WR_RESP);
  assign in_bresp  = ((state == WR_RESP) && wr_err) ? 2'b10 : 2'b00;
  assign in_bid    = cur_id;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ar_fire) state_nxt = RD;
               else if (aw_fire) state_nxt = WR;
      RD:      if (pop && in_rlast) state_nxt = IDLE;
      WR:      if ((issued == len_p1) && (acks == len_p1)) state_nxt = WR_RESP;
      WR_RESP: if (in_bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prio        <= 1'b0;
      cur_addr    <= '0;
      cur_id      <= '0;
      cur_len     <= '0;
      cur_size    <= '0;
      cur_burst   <= '0;
      issued      <= '0;
      acks        <= '0;
      popped      <= '0;
      wr_err      <= 1'b0;
      outstanding <= '0;
    end else begin
      state <= state_nxt;
      if (ar_fire) begin
        cur_addr  <= in_araddr;
        cur_id    <= in_arid;
        cur_len   <= in_arlen;
        cur_size  <= in_arsize;
        cur_burst <= in_arburst;
      end else if (aw_fire) begin
        cur_addr  <= in_awaddr;
        cur_id    <= in_awid;
        cur_len   <= in_awlen;
        cur_size  <= in_awsize;
        cur_burst <= in_awburst;
      end
      if (ar_fire || aw_fire) begin
        prio        <= ~prio;
        issued      <= '0;
        acks        <= '0;
        popped      <= '0;
        wr_err      <= 1'b0;
        outstanding <= '0;
      end else begin
        if (req_fire) begin
          issued   <= issued + 9'd1;
          cur_addr <= addr_nxt;
        end
        if ((state == WR) && mem_resp_valid) begin
          acks <= acks + 9'd1;
          if (mem_resp_err) wr_err <= 1'b1;
        end
        if (pop) popped <= popped + 8'd1;
        outstanding <= outstanding + CNT_W'(rd_fire) - CNT_W'(push);
      end
    end
  end

  // Credit check guarantees a push never lands on a full FIFO unless a pop frees it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_count <= '0;
      wptr       <= '0;
      rptr       <= '0;
    end else begin
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wptr] <= {mem_resp_err, mem_resp_rdata};
  end

endmodule
